inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
Boot-time programmer that drives the instruction RAM write port (is_write / im_addr / im_inst). It accepts a byte stream from a host-side link (UART RX or DMA byte channel) and assembles little-endian 32-bit words. It writes them to consecutive word addresses and holds the core in reset while the program is loaded. It sits between the host link and the instruction RAM write port, and its core_hold output gates the pipeline reset.

Parameters:
W, 32, data/address width; must equal the instruction RAM width.
DEPTH_WORDS, 2048, maximum program length in words accepted.
BASE_ADDR, 0, byte address of the first written word; multiple of 4.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a load session
byte_valid  in  1  byte_data holds a valid byte
byte_data  in  8  incoming stream byte
byte_ready  out  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready
is_write  out  1  instruction RAM write strobe, one cycle per word
im_addr  out  W  byte address of the write; RAM uses im_addr>>2
im_inst  out  W  instruction word to write
core_hold  out  1  high from start until done/err; holds the core in reset
busy  out  1  session in progress
done  out  1  sticky; load completed successfully
err  out  1  sticky; load aborted
word_cnt  out  W  words written this session

Behaviour:
- Reset (async, rst_n=0): state=IDLE; byte_ready=0, is_write=0, im_addr=BASE_ADDR, im_inst=0, core_hold=0, busy=0, done=0, err=0, word_cnt=0. Reset mid-session abandons the session with no further writes. Words already written stay in the RAM.
- States: IDLE, HDR, LOAD, [CHK], DONE, ERR.
- IDLE: byte_ready=0. On start: go to HDR, clear done/err/word_cnt, set core_hold=1 and busy=1, set byte index=0.
- HDR: byte_ready=1. Takes 4 bytes, LSB first, as length N.
  - After the 4th byte: N==0 goes to DONE; N>DEPTH_WORDS goes to ERR; otherwise go to LOAD.
- LOAD: byte_ready=1. Bytes shift into a 32-bit assembler, LSB first (byte 0 goes to bits 7:0).
  - Registered output: the cycle after the 4th byte of a word is accepted, is_write=1 for exactly one cycle.
  - im_inst=assembled word; im_addr=BASE_ADDR+4*word_cnt; word_cnt increments in that same cycle.
  - im_addr/im_inst hold their last value when is_write=0.
  - Back-to-back bytes every cycle must be sustained with no stall, i.e. one word write per 4 cycles.
  - After the N-th word write: go to DONE (or CHK when the feature is enabled).
- byte_valid gaps of any length are tolerated; partial word/length state is held.
- DONE: done=1, busy=0, core_hold=0, byte_ready=0.
- ERR: err=1, busy=0, core_hold=0, byte_ready=0.
- DONE/ERR return to IDLE on the next cycle; done/err stay set until the next start.
- start while busy is ignored. start in the same cycle that DONE is entered is also ignored.
- Address arithmetic is modulo 2^W; with a legal N no wrap occurs.

Optional Feature:
INST_LOADER_CHECKSUM_EN
- With the macro defined: after the N data words, state CHK takes 4 more bytes (LSB first) as an expected checksum.
  - Running sum = modulo-2^W sum of all data words, reset at start.
  - Mismatch goes to ERR (words already written stay in the RAM); match goes to DONE.
  - For N==0 the checksum is still read and must equal 0.
- Without it: no CHK state; LOAD goes directly to DONE; no adder is synthesized.

Test Plan:
- Reset, then start; stream N=2 (bytes 02 00 00 00), then 13 00 00 00, 93 00 10 00 every cycle -> is_write pulses twice, four cycles apart. First write: im_addr=0, im_inst=0x00000013. Second write: im_addr=4, im_inst=0x00100093. Then done=1, core_hold=0, word_cnt=2.
- Same stream with byte_valid toggled 1/0 every cycle -> identical writes and data, spaced 8 cycles apart.
- N=0x00000801 (2049 > DEPTH_WORDS) -> no is_write; err=1, done=0, byte_ready=0 after the header.
- Assert rst_n=0 after 6 bytes of a 3-word load -> all outputs return to reset values at once. A new start plus full stream then loads correctly from im_addr=0.
- Pulse start during LOAD -> ignored; word_cnt and im_addr sequence continue unchanged.
- With INST_LOADER_CHECKSUM_EN defined: words 0x00000013 and 0x00100093, checksum 0x001000A6 -> done=1. Checksum 0x001000A7 -> err=1, and both words are already written.

Source files
------------

// File: rtl/inst_loader.sv
// Boot loader: assembles a little-endian byte stream (length header, then words) into instruction RAM writes.
// Latency: is_write is registered, one cycle after the 4th byte of a word; sustains one word per 4 byte cycles.
// Backpressure: byte_ready is high only in HDR/LOAD(/CHK); byte_valid gaps of any length hold partial state.
// Optional feature: define INST_LOADER_CHECKSUM_EN to read a trailing 32-bit sum of the data words.
module inst_loader #(
    parameter int unsigned     W           = 32,
    parameter int unsigned     DEPTH_WORDS = 2048,
    parameter logic [W-1:0]    BASE_ADDR   = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    output logic         byte_ready,
    output logic         is_write,
    output logic [W-1:0] im_addr,
    output logic [W-1:0] im_inst,
    output logic         core_hold,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] word_cnt
);

    localparam logic [W-1:0] DEPTH_W = W'(DEPTH_WORDS);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, LOAD, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} state_t;
`endif

    state_t       state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [W-1:0] asm_q, asm_d;
    logic [W-1:0] len_q, len_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] inst_q, inst_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         wr_q, wr_d;
    logic         hold_q, hold_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [W-1:0] sum_q, sum_d;
`endif

    logic xfer;
    logic [W-1:0] shifted;

    // Ready is a pure function of state so the host sees it without extra latency.
`ifdef INST_LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
`else
    assign byte_ready = (state_q == HDR) || (state_q == LOAD);
`endif
    assign xfer    = byte_valid & byte_ready;
    assign shifted = {byte_data, asm_q[W-1:8]};

    // Next-state and datapath: bytes shift in LSB first; the 4th byte completes a field.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        len_d   = len_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HDR;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                    idx_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
                    asm_d = shifted;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        len_d = shifted;
                        if (shifted == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end else if (shifted > DEPTH_W) begin
                            state_d = ERR;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    asm_d = shifted;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wr_d   = 1'b1;
                        inst_d = shifted;
                        addr_d = BASE_ADDR + {cnt_q[W-3:0], 2'b00};
                        cnt_d  = cnt_q + W'(1);
`ifdef INST_LOADER_CHECKSUM_EN
                        sum_d  = sum_q + shifted;
                        if (cnt_d == len_q) state_d = CHK;
`else
                        if (cnt_d == len_q) state_d = DONE;
`endif
                    end
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    asm_d = shifted;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = (shifted == sum_q) ? DONE : ERR;
                end
            end
`endif
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Session end: release the core and set the sticky status flag on entry.
        if (state_d == DONE && state_q != DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            hold_d = 1'b0;
        end
        if (state_d == ERR && state_q != ERR) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
            hold_d = 1'b0;
        end
    end

    // State and datapath registers; reset abandons any session in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            len_q   <= '0;
            addr_q  <= BASE_ADDR;
            inst_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign is_write  = wr_q;
    assign im_addr   = addr_q;
    assign im_inst   = inst_q;
    assign core_hold = hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: normal loads, byte gaps, oversize header, mid-session reset, ignored start.
// Writes are captured at negedge into queues and compared against hand-computed addresses/data.
// Every wait on the DUT is bounded by a cycle budget.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, is_write, core_hold, busy, done, err;
    logic [31:0] im_addr, im_inst, word_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0]  stream_q[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [31:0] sum;

    inst_loader #(.W(32), .DEPTH_WORDS(2048), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .is_write(is_write), .im_addr(im_addr), .im_inst(im_inst),
        .core_hold(core_hold), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (is_write === 1'b1) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_inst);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        stream_q.push_back(w[7:0]);
        stream_q.push_back(w[15:8]);
        stream_q.push_back(w[23:16]);
        stream_q.push_back(w[31:24]);
    endtask

    task automatic new_stream(input logic [31:0] n);
        stream_q.delete();
        sum = 32'h0;
        push_word(n);
    endtask

    task automatic add_word(input logic [31:0] w);
        push_word(w);
        sum = sum + w;
    endtask

    task automatic end_stream();
`ifdef INST_LOADER_CHECKSUM_EN
        push_word(sum);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends bytes 0..limit-1 of stream_q; gap inserts an idle cycle after each byte;
    // start is also raised while byte start_at is offered.
    task automatic send(input int gap, input int start_at, input int limit);
        int n;
        for (int i = 0; i < limit && i < stream_q.size(); i++) begin
            byte_data  = stream_q[i];
            byte_valid = 1'b1;
            if (i == start_at) start = 1'b1;
            n = 0;
            while (byte_ready !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) begin
                n_cmp++; n_bad++;
                $display("FAIL byte_ready_timeout: byte %0d never accepted, byte_ready=%b required 1", i, byte_ready);
                byte_valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (gap != 0) begin
                byte_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL rst_byte_ready: got %b want 0", byte_ready); end
        n_cmp++; if (is_write !== 1'b0) begin n_bad++; $display("FAIL rst_is_write: got %b want 0", is_write); end
        n_cmp++; if (im_addr !== 32'h0) begin n_bad++; $display("FAIL rst_im_addr: got %h want 0", im_addr); end
        n_cmp++; if ({core_hold, busy, done, err} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", {core_hold, busy, done, err}); end
        n_cmp++; if (word_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_word_cnt: got %0d want 0", word_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load(input int gap);
        clear_writes();
        new_stream(32'd2);
        add_word(32'h00000013);
        add_word(32'h00100093);
        end_stream();
        pulse_start();
        n_cmp++; if ({core_hold, busy, byte_ready} !== 3'b111) begin n_bad++; $display("FAIL load_started: hold/busy/ready got %b want 111", {core_hold, busy, byte_ready}); end
        send(gap, -1, 1000);
        if (gap == 0) begin
            n_cmp++; if ({busy, byte_ready} !== 2'b00) begin n_bad++; $display("FAIL load_end_busy_ready: got %b want 00", {busy, byte_ready}); end
        end
        @(posedge clk); #1;
        n_cmp++; if (wr_addr.size() != 2) begin
            n_bad++; $display("FAIL load_write_count(gap=%0d): got %0d want 2", gap, wr_addr.size());
        end else begin
            n_cmp++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00000013) begin n_bad++; $display("FAIL load_w0: got %h/%h want 0/00000013", wr_addr[0], wr_data[0]); end
            n_cmp++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00100093) begin n_bad++; $display("FAIL load_w1: got %h/%h want 4/00100093", wr_addr[1], wr_data[1]); end
            n_cmp++; if (wr_cyc[1] - wr_cyc[0] != (gap != 0 ? 8 : 4)) begin n_bad++; $display("FAIL load_spacing(gap=%0d): got %0d want %0d", gap, wr_cyc[1] - wr_cyc[0], (gap != 0 ? 8 : 4)); end
        end
        n_cmp++; if ({done, err, core_hold} !== 3'b100) begin n_bad++; $display("FAIL load_status: done/err/hold got %b want 100", {done, err, core_hold}); end
        n_cmp++; if (word_cnt !== 32'd2) begin n_bad++; $display("FAIL load_word_cnt: got %0d want 2", word_cnt); end
        n_cmp++; if (im_inst !== 32'h00100093) begin n_bad++; $display("FAIL load_inst_hold: got %h want 00100093", im_inst); end
    endtask

    task automatic test_zero_len();
        clear_writes();
        new_stream(32'd0);
        end_stream();
        pulse_start();
        send(0, -1, 1000);
        @(posedge clk); #1;
        n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); end
        n_cmp++; if ({done, err, word_cnt} !== {2'b10, 32'd0}) begin n_bad++; $display("FAIL zero_status: done=%b err=%b cnt=%0d want 1 0 0", done, err, word_cnt); end
    endtask

    task automatic test_oversize();
        clear_writes();
        new_stream(32'h00000801);
        pulse_start();
        send(0, -1, 4);
        n_cmp++; if ({err, done, byte_ready, core_hold, busy} !== 5'b10000) begin n_bad++; $display("FAIL oversize_status: err/done/ready/hold/busy got %b want 10000", {err, done, byte_ready, core_hold, busy}); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL oversize_writes: got %0d want 0", wr_addr.size()); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oversize_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid_load();
        clear_writes();
        new_stream(32'd3);
        add_word(32'h11223344);
        add_word(32'h55667788);
        add_word(32'h99AABBCC);
        end_stream();
        pulse_start();
        send(0, -1, 6);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({byte_ready, is_write, core_hold, busy, done, err} !== 6'b0) begin n_bad++; $display("FAIL midrst_flags: got %b want 000000", {byte_ready, is_write, core_hold, busy, done, err}); end
        n_cmp++; if (im_addr !== 32'h0 || im_inst !== 32'h0 || word_cnt !== 32'h0) begin n_bad++; $display("FAIL midrst_regs: addr=%h inst=%h cnt=%0d want 0 0 0", im_addr, im_inst, word_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL midrst_no_writes: got %0d want 0", wr_addr.size()); end
        pulse_start();
        send(0, -1, 1000);
        @(posedge clk); #1;
        n_cmp++; if (wr_addr.size() != 3) begin
            n_bad++; $display("FAIL reload_count: got %0d want 3", wr_addr.size());
        end else begin
            n_cmp++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h11223344) begin n_bad++; $display("FAIL reload_w0: got %h/%h want 0/11223344", wr_addr[0], wr_data[0]); end
            n_cmp++; if (wr_addr[2] !== 32'h8 || wr_data[2] !== 32'h99AABBCC) begin n_bad++; $display("FAIL reload_w2: got %h/%h want 8/99aabbcc", wr_addr[2], wr_data[2]); end
        end
        n_cmp++; if (done !== 1'b1 || word_cnt !== 32'd3) begin n_bad++; $display("FAIL reload_status: done=%b cnt=%0d want 1 3", done, word_cnt); end
    endtask

    task automatic test_start_in_load();
        clear_writes();
        new_stream(32'd3);
        add_word(32'hDEADBEEF);
        add_word(32'h00000001);
        add_word(32'hCAFEF00D);
        end_stream();
        pulse_start();
        send(0, 9, 1000);
        @(posedge clk); #1;
        n_cmp++; if (wr_addr.size() != 3) begin
            n_bad++; $display("FAIL startload_count: got %0d want 3", wr_addr.size());
        end else begin
            n_cmp++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00000001) begin n_bad++; $display("FAIL startload_w1: got %h/%h want 4/00000001", wr_addr[1], wr_data[1]); end
            n_cmp++; if (wr_addr[2] !== 32'h8 || wr_data[2] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL startload_w2: got %h/%h want 8/cafef00d", wr_addr[2], wr_data[2]); end
        end
        n_cmp++; if (done !== 1'b1 || word_cnt !== 32'd3) begin n_bad++; $display("FAIL startload_status: done=%b cnt=%0d want 1 3", done, word_cnt); end
    endtask

`ifdef INST_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_writes();
        new_stream(32'd2);
        add_word(32'h00000013);
        add_word(32'h00100093);
        push_word(32'h001000A7);
        pulse_start();
        send(0, -1, 1000);
        n_cmp++; if ({err, done} !== 2'b10) begin n_bad++; $display("FAIL chk_bad_status: err/done got %b want 10", {err, done}); end
        n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL chk_bad_writes: got %0d want 2", wr_addr.size()); end
        clear_writes();
        new_stream(32'd2);
        add_word(32'h00000013);
        add_word(32'h00100093);
        push_word(32'h001000A6);
        pulse_start();
        send(0, -1, 1000);
        n_cmp++; if ({err, done} !== 2'b01) begin n_bad++; $display("FAIL chk_good_status: err/done got %b want 01", {err, done}); end
    endtask
`endif

    initial begin
        test_reset();
        test_load(0);
        test_load(1);
        test_zero_len();
        test_oversize();
        test_reset_mid_load();
        test_start_in_load();
`ifdef INST_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
